div_issue_ctrl: RTL and testbench

Issue/writeback stage wrapped around the 32-bit unsigned iterative divider core (start/busy handshake, q/r outputs). Accepts DIV/DIVU requests from the CPU execute stage, converts signed operands to magnitudes, launches the core and stalls the pipeline while it runs. Sign-corrects the quotient and remainder and commits them to the architectural HI (remainder) and LO (quotient) registers. Also serves MTHI/MTLO writes.

---
 rtl/div_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// Issue/writeback control around a 32-bit unsigned iterative divider core.
// Handles DIV/DIVU sign handling, core handshake with timeout, and HI/LO (MTHI/MTLO) ownership.
module div_issue_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        is_signed,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        dz,
  output logic        err,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO, WRITE} state_t;

  state_t          state_q, state_d;
  logic            sa_q, sa_d, sb_q, sb_d;
  logic [31:0]     q_q, q_d, r_q, r_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     div_a_q, div_a_d, div_b_q, div_b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dz_q, dz_d, done_q, done_d, err_q, err_d, start_q, start_d;

  logic            neg_a, neg_b;
  logic [31:0]     mag_a, mag_b;

  assign neg_a = is_signed & op_a[31];
  assign neg_b = is_signed & op_b[31];
  assign mag_a = neg_a ? -op_a : op_a;
  assign mag_b = neg_b ? -op_b : op_b;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    q_d     = q_q;
    r_d     = r_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    start_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (req) begin
          dz_d    = (op_b == 32'd0);
          div_a_d = mag_a;
          div_b_d = mag_b;
          if (op_b == 32'd0) begin
            // Divide by zero bypasses the core: preload the fixed result with no sign fix-up.
            sa_d    = 1'b0;
            sb_d    = 1'b0;
            q_d     = 32'hFFFF_FFFF;
            r_d     = op_a;
            state_d = WRITE;
          end else begin
            sa_d    = neg_a;
            sb_d    = neg_b;
            start_d = 1'b1;
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = div_busy ? WAIT_LO : WAIT_HI;
      end
      WAIT_HI: begin
        if (div_busy) begin
          cnt_d   = '0;
          state_d = WAIT_LO;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!div_busy) begin
          q_d     = div_q;
          r_d     = div_r;
          state_d = WRITE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        lo_d    = (sa_q ^ sb_q) ? -q_q : q_q;
        hi_d    = sa_q ? -r_q : r_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values, matching hardware.
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      q_q     <= q_d;
      r_q     <= r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  // Reset drops state to IDLE asynchronously, but req alone would still raise stall without the gate.
  assign stall     = rst & ((state_q != IDLE) | req);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign done      = done_q;
  assign dz        = dz_q;
  assign err       = err_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign div_start = start_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: behavioural divider core stub, vector table,
// hand-written corner sequences and randomized operands against a plain-arithmetic model.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, is_signed, hi_we, lo_we;
  logic [31:0] op_a, op_b, wdata;
  logic        stall, done, dz, err, div_start;
  logic [31:0] hi, lo, div_a, div_b;
  logic [31:0] div_q = 32'd0;
  logic [31:0] div_r = 32'd0;
  logic        div_busy = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  int stub_lat  = 3;
  bit stub_dead = 1'b0;
  int stub_cnt  = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .is_signed(is_signed), .op_a(op_a), .op_b(op_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .stall(stall), .hi(hi), .lo(lo),
    .done(done), .dz(dz), .err(err), .div_a(div_a), .div_b(div_b), .div_start(div_start),
    .div_q(div_q), .div_r(div_r), .div_busy(div_busy)
  );

  // Unsigned iterative core stub: busy rises the edge after start, stays high stub_lat+1 cycles.
  always @(posedge clk) begin
    if (div_start && !stub_dead) begin
      div_busy <= 1'b1;
      stub_cnt <= stub_lat;
      div_q    <= (div_b != 32'd0) ? div_a / div_b : 32'hFFFF_FFFF;
      div_r    <= (div_b != 32'd0) ? div_a % div_b : div_a;
    end else if (div_busy) begin
      if (stub_cnt == 0) div_busy <= 1'b0;
      else stub_cnt <= stub_cnt - 1;
    end
  end

  typedef struct {
    logic        s;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo, lo_first, start_a, start_b;
    logic        dz, stall_at_done;
    int          done_edge, fall_edge, start_cnt, stall_cnt;
  } res_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic s, input logic [31:0] x);
    return (s && x[31]) ? (~x + 32'd1) : x;
  endfunction

  // Reference: truncating division on wide signed integers, fixed result for a zero divisor.
  task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] rhi, output logic [31:0] rlo);
    longint x, y, q, r;
    if (b == 32'd0) begin
      rhi = a;
      rlo = 32'hFFFF_FFFF;
    end else if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      q = x / y;
      r = x % y;
      rlo = q[31:0];
      rhi = r[31:0];
    end else begin
      rlo = a / b;
      rhi = a % b;
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_reached"}, 32'(seen), 32'd1);
  endtask

  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic with_lo, input logic [31:0] wd, output res_t r);
    bit seen_busy = 1'b0;
    r = '{default: 0};
    r.done_edge = -1;
    r.fall_edge = -1;
    @(negedge clk);
    req = 1'b1; is_signed = s; op_a = a; op_b = b; lo_we = with_lo; wdata = wd;
    #1;
    if (stall) r.stall_cnt++;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        req = 1'b0;
        lo_we = 1'b0;
        r.lo_first = lo;
      end
      if (div_start) begin
        r.start_cnt++;
        r.start_a = div_a;
        r.start_b = div_b;
      end
      if (div_busy) seen_busy = 1'b1;
      else if (seen_busy && r.fall_edge < 0) r.fall_edge = i;
      if (done) begin
        r.done_edge = i;
        r.stall_at_done = stall;
        break;
      end
      if (stall) r.stall_cnt++;
    end
    r.hi = hi;
    r.lo = lo;
    r.dz = dz;
  endtask

  vec_t vecs[9];
  res_t res;
  logic [31:0] ehi, elo, hold_hi, hold_lo;
  int   err_edge;

  initial begin
    vecs[0] = '{1'b0, 32'hFFFF_FFF0, 32'd5,        32'h0000_0000, 32'h3333_3330, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[3] = '{1'b1, 32'd26,        32'd0,        32'd26,        32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{1'b0, 32'd26,        32'd0,        32'd26,        32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 1'b0};
    vecs[6] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[7] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
    vecs[8] = '{1'b0, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC, 1'b0};

    rst = 1'b0; req = 1'b1; is_signed = 1'b0; op_a = '0; op_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #12;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_div_ab", div_a | div_b, 32'd0);
    check("rst_flags", 32'({div_start, done, dz, err}), 32'd0);
    check("rst_stall_forced_low", 32'(stall), 32'd0);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;

    foreach (vecs[k]) begin
      do_div(vecs[k].s, vecs[k].a, vecs[k].b, 1'b0, 32'd0, res);
      check($sformatf("v%0d_done_reached", k), 32'(res.done_edge >= 0), 32'd1);
      check($sformatf("v%0d_hi", k), res.hi, vecs[k].hi);
      check($sformatf("v%0d_lo", k), res.lo, vecs[k].lo);
      check($sformatf("v%0d_dz", k), 32'(res.dz), 32'(vecs[k].dz));
      check($sformatf("v%0d_stall_at_done", k), 32'(res.stall_at_done), 32'd0);
      if (vecs[k].dz) begin
        check($sformatf("v%0d_no_start", k), 32'(res.start_cnt), 32'd0);
        check($sformatf("v%0d_done_edge", k), 32'(res.done_edge), 32'd2);
        check($sformatf("v%0d_stall_cycles", k), 32'(res.stall_cnt), 32'd2);
      end else begin
        check($sformatf("v%0d_one_start", k), 32'(res.start_cnt), 32'd1);
        check($sformatf("v%0d_div_a", k), res.start_a, mag(vecs[k].s, vecs[k].a));
        check($sformatf("v%0d_div_b", k), res.start_b, mag(vecs[k].s, vecs[k].b));
        check($sformatf("v%0d_fall_to_done", k), 32'(res.done_edge - res.fall_edge), 32'd2);
        check($sformatf("v%0d_stall_cycles", k), 32'(res.stall_cnt), 32'(res.done_edge));
      end
      @(posedge clk); #1;
      check($sformatf("v%0d_done_one_cycle", k), 32'(done), 32'd0);
    end

    // MTHI/MTLO in IDLE, then preload for the timeout case.
    @(negedge clk); hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1; check("mthi_a5", hi, 32'hA5A5_A5A5);
    @(negedge clk); wdata = 32'h1111_1111;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2222_2222;
    @(negedge clk); lo_we = 1'b0;
    check("preload_hi", hi, 32'h1111_1111);
    check("preload_lo", lo, 32'h2222_2222);

    // Core never raises busy: err pulse, HI/LO untouched.
    stub_dead = 1'b1;
    err_edge = -1;
    @(negedge clk); req = 1'b1; is_signed = 1'b0; op_a = 32'd100; op_b = 32'd3;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (i == 1) req = 1'b0;
      if (err) begin
        err_edge = i;
        break;
      end
    end
    check("timeout_err_edge", 32'(err_edge), 32'd66);
    check("timeout_hi_kept", hi, 32'h1111_1111);
    check("timeout_lo_kept", lo, 32'h2222_2222);
    check("timeout_idle_stall", 32'(stall), 32'd0);
    check("timeout_no_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("timeout_err_one_cycle", 32'(err), 32'd0);
    stub_dead = 1'b0;

    // MTLO while the FSM is in WAIT_LO is ignored.
    stub_lat = 10;
    @(negedge clk); req = 1'b1; is_signed = 1'b0; op_a = 32'd1000; op_b = 32'd7;
    @(posedge clk); #1; req = 1'b0;
    repeat (3) @(posedge clk);
    hold_lo = lo;
    @(negedge clk); lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1; lo_we = 1'b0;
    check("mtlo_wait_lo_ignored", lo, hold_lo);
    wait_done("mtlo_wait");
    check("mtlo_wait_final_lo", lo, 32'd142);
    check("mtlo_wait_final_hi", hi, 32'd6);

    // req together with MTLO: write lands, then the quotient overwrites it.
    stub_lat = 2;
    do_div(1'b0, 32'd100, 32'd7, 1'b1, 32'h1234_5678, res);
    check("req_lo_we_first", res.lo_first, 32'h1234_5678);
    check("req_lo_we_final_lo", res.lo, 32'd14);
    check("req_lo_we_final_hi", res.hi, 32'd2);

    // Reset in WAIT_LO with dz set from a prior request.
    do_div(1'b0, 32'd26, 32'd0, 1'b0, 32'd0, res);
    check("pre_reset_dz", 32'(res.dz), 32'd1);
    stub_lat = 20;
    @(negedge clk); req = 1'b1; is_signed = 1'b0; op_a = 32'd5000; op_b = 32'd3;
    repeat (4) @(posedge clk);
    @(negedge clk); #2; rst = 1'b0; #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_div_ab", div_a | div_b, 32'd0);
    check("midrst_flags", 32'({div_start, done, dz, err}), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    req = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (30) @(posedge clk);
    stub_lat = 3;
    do_div(1'b0, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 32'd0, res);
    check("postrst_done_reached", 32'(res.done_edge >= 0), 32'd1);
    check("postrst_lo", res.lo, 32'd0);
    check("postrst_hi", res.hi, 32'h0000_FFFF);

    // Randomized operands and core latency against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      logic        s;
      logic [31:0] a, b;
      int          sel;
      s   = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = int'($urandom_range(0, 7));
      case (sel)
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      stub_lat = int'($urandom_range(0, 6));
      ref_div(s, a, b, ehi, elo);
      do_div(s, a, b, 1'b0, 32'd0, res);
      check($sformatf("rnd%0d_hi s=%0d a=%08h b=%08h", n, s, a, b), res.hi, ehi);
      check($sformatf("rnd%0d_lo s=%0d a=%08h b=%08h", n, s, a, b), res.lo, elo);
      check($sformatf("rnd%0d_dz", n), 32'(res.dz), 32'(b == 32'd0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
